// File: rtl/bram_ctrl.sv
// bram_ctrl: single-port block-RAM controller with a valid/ready request
// channel and a valid/ready response channel.
// Optional feature macro: BRAM_CTRL_BYTE_EN_EN. When it is defined, writes
// honour req_be: partial writes become read-modify-write and a write with
// no enabled bytes is a no-op. When it is undefined, req_be is ignored and
// every write stores the whole word.
module bram_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 12
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_BITS-1:0]      req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_be,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      ram_enable,
    output logic                      ram_write_enable,
    output logic [ADDR_BITS-1:0]      ram_address,
    output logic [DATA_WIDTH-1:0]     ram_input_data,
    input  logic [DATA_WIDTH-1:0]     ram_output_data
);

    localparam int BE_W = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RESP     = 3'd2
`ifdef BRAM_CTRL_BYTE_EN_EN
        ,
        RMW_WAIT = 3'd3,
        RMW_WR   = 3'd4
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    accept;

`ifdef BRAM_CTRL_BYTE_EN_EN
    // Request captured for the read-modify-write sequence.
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]         be_q, be_d;
`else
    // Byte enables have no meaning when every write is a full-word write.
    logic                    unused_be;
    assign unused_be = ^req_be;
`endif

    // Reset also closes the request channel so nothing is accepted while it is held.
    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    // Next-state, response and memory-port decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d          = state_q;
        rsp_valid_d      = rsp_valid_q;
        rsp_rdata_d      = rsp_rdata_q;
`ifdef BRAM_CTRL_BYTE_EN_EN
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        be_d             = be_q;
`endif
        ram_enable       = 1'b0;
        ram_write_enable = 1'b0;
        ram_address      = '0;
        ram_input_data   = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    ram_address    = req_addr;
                    ram_input_data = req_wdata;
                    if (!req_we) begin
                        ram_enable = 1'b1;
                        state_d    = RD_WAIT;
                    end
`ifdef BRAM_CTRL_BYTE_EN_EN
                    else if (&req_be) begin
                        ram_enable       = 1'b1;
                        ram_write_enable = 1'b1;
                        rsp_valid_d      = 1'b1;
                        state_d          = RESP;
                    end else if (req_be == '0) begin
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        // Read the old word now; merge once it comes back.
                        ram_enable = 1'b1;
                        addr_d     = req_addr;
                        wdata_d    = req_wdata;
                        be_d       = req_be;
                        state_d    = RMW_WAIT;
                    end
`else
                    else begin
                        ram_enable       = 1'b1;
                        ram_write_enable = 1'b1;
                        rsp_valid_d      = 1'b1;
                        state_d          = RESP;
                    end
`endif
                end
            end
            RD_WAIT: begin
                rsp_rdata_d = ram_output_data;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
`ifdef BRAM_CTRL_BYTE_EN_EN
            RMW_WAIT: begin
                // Disabled bytes take the old memory contents.
                for (int i = 0; i < BE_W; i++) begin
                    if (!be_q[i]) begin
                        wdata_d[8*i +: 8] = ram_output_data[8*i +: 8];
                    end
                end
                state_d = RMW_WR;
            end
            RMW_WR: begin
                ram_enable       = 1'b1;
                ram_write_enable = 1'b1;
                ram_address      = addr_q;
                ram_input_data   = wdata_q;
                rsp_valid_d      = 1'b1;
                state_d          = RESP;
            end
`endif
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and response registers; reset drops any in-flight transaction.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef BRAM_CTRL_BYTE_EN_EN
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef BRAM_CTRL_BYTE_EN_EN
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
`endif
        end
    end

endmodule

// File: tb/tb_bram_ctrl.sv
// tb_bram_ctrl: directed, table-driven bench for bram_ctrl with a
// registered read-first memory attached to the RAM port.
module tb_bram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        ram_enable;
    logic        ram_write_enable;
    logic [11:0] ram_address;
    logic [31:0] ram_input_data;
    logic [31:0] ram_output_data = '0;

    int errors = 0;
    int checks = 0;
    int en_count = 0;
    int bad_we = 0;

    always #5 clk = ~clk;

    bram_ctrl #(.DATA_WIDTH(32), .ADDR_BITS(12)) dut (
        .clock            (clk),
        .reset            (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_be           (req_be),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_rdata        (rsp_rdata),
        .ram_enable       (ram_enable),
        .ram_write_enable (ram_write_enable),
        .ram_address      (ram_address),
        .ram_input_data   (ram_input_data),
        .ram_output_data  (ram_output_data)
    );

    // Registered read-first block RAM.
    logic [31:0] mem [4096];

    always @(posedge clk) begin
        if (ram_enable) begin
            ram_output_data <= mem[ram_address];
            if (ram_write_enable) mem[ram_address] <= ram_input_data;
            en_count <= en_count + 1;
        end
        if (ram_write_enable && !ram_enable) bad_we <= bad_we + 1;
    end

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;
        logic [31:0] rdata;
        int          en;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Present one request, return latency (edges to rsp_valid), data and RAM enables.
    task automatic do_txn(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output int lat, output logic [31:0] rd,
                          output int en_delta);
        int e0;
        @(negedge clk);
        e0 = en_count;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        check("ready_before_accept", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = ~we; req_addr = 12'hABC; req_wdata = 32'h5A5A5A5A; req_be = 4'h5;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) lat = 99;
        rd = rsp_rdata;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        en_delta = en_count - e0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int en_delta;
        logic [31:0] rd;
        do_txn(v.we, v.addr, v.wdata, v.be, lat, rd, en_delta);
        check($sformatf("latency %s @%h", v.we ? "W" : "R", v.addr), lat, v.lat);
        check($sformatf("rdata %s @%h", v.we ? "W" : "R", v.addr), rd, v.rdata);
        check($sformatf("ram_en %s @%h", v.we ? "W" : "R", v.addr), en_delta, v.en);
    endtask

    // Accept a request and return #1 after the acceptance edge, leaving the response pending.
    task automatic start_txn(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Assert reset mid-transaction, check outputs drop at once, then release.
    task automatic reset_mid(input string tag);
        int seen;
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h030; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
        #1;
        check({tag, " rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, " ram_enable"}, {31'b0, ram_enable}, 32'd0);
        check({tag, " req_ready"}, {31'b0, req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check({tag, " no_response"}, seen, 32'd0);
    endtask

    initial begin
        int e0;
        int waited;
        for (int i = 0; i < 4096; i++) mem[i] = '0;

        // Reset state, with a request already pending.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h010;
        repeat (2) @(posedge clk);
        #1;
        check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset req_ready", {31'b0, req_ready}, 32'd0);
        check("reset ram_enable", {31'b0, ram_enable}, 32'd0);
        check("reset ram_we", {31'b0, ram_write_enable}, 32'd0);
        check("reset en_count", en_count, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("idle req_ready", {31'b0, req_ready}, 32'd1);

        // {we, addr, wdata, be, latency, rsp_rdata at response, RAM enable pulses}
        vecs.push_back('{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 1, 32'h00000000, 1});
        vecs.push_back('{1'b0, 12'h010, 32'h00000000, 4'h0, 2, 32'hDEADBEEF, 1});
        vecs.push_back('{1'b1, 12'h020, 32'h12345678, 4'hF, 1, 32'hDEADBEEF, 1});
        vecs.push_back('{1'b0, 12'h020, 32'h00000000, 4'h0, 2, 32'h12345678, 1});
        vecs.push_back('{1'b1, 12'hFFF, 32'hA5A5A5A5, 4'hF, 1, 32'h12345678, 1});
        vecs.push_back('{1'b0, 12'hFFF, 32'h00000000, 4'h0, 2, 32'hA5A5A5A5, 1});
        vecs.push_back('{1'b0, 12'h000, 32'h00000000, 4'h0, 2, 32'h00000000, 1});
        vecs.push_back('{1'b1, 12'h050, 32'h0F0F0F0F, 4'hF, 1, 32'h00000000, 1});
        vecs.push_back('{1'b0, 12'h050, 32'h00000000, 4'h0, 2, 32'h0F0F0F0F, 1});
`ifdef BRAM_CTRL_BYTE_EN_EN
        vecs.push_back('{1'b1, 12'h010, 32'h000000AA, 4'h1, 3, 32'h0F0F0F0F, 2});
        vecs.push_back('{1'b0, 12'h010, 32'h00000000, 4'h0, 2, 32'hDEADBEAA, 1});
        vecs.push_back('{1'b1, 12'h020, 32'hFFFFFFFF, 4'h0, 1, 32'hDEADBEAA, 0});
        vecs.push_back('{1'b0, 12'h020, 32'h00000000, 4'h0, 2, 32'h12345678, 1});
        vecs.push_back('{1'b1, 12'h050, 32'hAABBCCDD, 4'h6, 3, 32'h12345678, 2});
        vecs.push_back('{1'b0, 12'h050, 32'h00000000, 4'h0, 2, 32'h0FBBCC0F, 1});
`else
        vecs.push_back('{1'b1, 12'h040, 32'h11223344, 4'h1, 1, 32'h0F0F0F0F, 1});
        vecs.push_back('{1'b0, 12'h040, 32'h00000000, 4'h0, 2, 32'h11223344, 1});
`endif
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Response back-pressure: held response stays put, new requests are ignored.
        start_txn(1'b0, 12'hFFF, 32'h0, 4'h0);
        waited = 0;
        while (!rsp_valid && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("stall rsp_valid_rose", {31'b0, rsp_valid}, 32'd1);
        e0 = en_count;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h060; req_wdata = 32'hBAD0BAD0; req_be = 4'hF;
            #1;
            check($sformatf("stall%0d rsp_valid", c), {31'b0, rsp_valid}, 32'd1);
            check($sformatf("stall%0d rsp_rdata", c), rsp_rdata, 32'hA5A5A5A5);
            check($sformatf("stall%0d req_ready", c), {31'b0, req_ready}, 32'd0);
            check($sformatf("stall%0d ram_enable", c), {31'b0, ram_enable}, 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        check("stall en_pulses", en_count - e0, 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("stall released rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("stall released req_ready", {31'b0, req_ready}, 32'd1);
        run_vec('{1'b0, 12'h060, 32'h0, 4'h0, 2, 32'h00000000, 1});

        // Reset during RD_WAIT drops the read; leave a nonzero rsp_rdata first.
        run_vec('{1'b0, 12'hFFF, 32'h0, 4'h0, 2, 32'hA5A5A5A5, 1});
        start_txn(1'b0, 12'h020, 32'h0, 4'h0);
        reset_mid("rst_rd_wait");
        run_vec('{1'b0, 12'h020, 32'h0, 4'h0, 2, 32'h12345678, 1});

`ifdef BRAM_CTRL_BYTE_EN_EN
        // Reset during RMW_WAIT: write never lands.
        run_vec('{1'b1, 12'h030, 32'h01020304, 4'hF, 1, 32'h12345678, 1});
        start_txn(1'b1, 12'h030, 32'h0000FFFF, 4'h3);
        reset_mid("rst_rmw_wait");
        run_vec('{1'b0, 12'h030, 32'h0, 4'h0, 2, 32'h01020304, 1});

        // Reset during RMW_WR, before the write edge: write suppressed.
        start_txn(1'b1, 12'h030, 32'h0000FFFF, 4'h3);
        @(posedge clk);
        #1;
        check("rmw_wr ram_enable", {31'b0, ram_enable}, 32'd1);
        check("rmw_wr ram_we", {31'b0, ram_write_enable}, 32'd1);
        check("rmw_wr merged data", ram_input_data, 32'h0102FFFF);
        reset_mid("rst_rmw_wr");
        run_vec('{1'b0, 12'h030, 32'h0, 4'h0, 2, 32'h01020304, 1});
`endif

        check("we_without_enable", bad_we, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
